// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared types and defaults for the shift arbiter
package shift_arb_pkg;
    typedef enum logic {EMPTY, FULL} outq_state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ = 4;
endpackage

// File: rtl/shifter.sv
// shifter: combinational logical/arithmetic barrel shifter
module shifter #(
    parameter int WIDTH = 8,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    shamt,
    input  logic             right,
    input  logic             arith,
    output logic [WIDTH-1:0] dout
);
    logic signed [WIDTH-1:0] sra;
    always_comb begin
        sra = $signed(din) >>> shamt;
        dout = right ? (arith ? sra : din >> shamt) : din << shamt;
    end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one shifter between NREQ requesters
module shift_arbiter import shift_arb_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ = DEF_NREQ,
    localparam int SW = $clog2(WIDTH),
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_din,
    input  logic [NREQ*SW-1:0]    req_shamt,
    input  logic [NREQ-1:0]       req_right,
    input  logic [NREQ-1:0]       req_arith,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_dout,
    output logic [IDW-1:0]        res_id
);
    outq_state_t state_q, state_d;
    logic [WIDTH-1:0] res_dout_q, res_dout_d, sh_dout;
    logic [IDW-1:0] res_id_q, res_id_d, last_grant_q, last_grant_d, grant;
    logic found, can_accept, xfer;

    // Lowest offset from last+1 wins; NREQ is a power of two so the index wraps for free.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] last);
        logic [IDW-1:0] idx;
        rr_pick = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + IDW'(k);
            if (v[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    shifter #(.WIDTH(WIDTH)) u_shifter (
        .din  (req_din[grant*WIDTH +: WIDTH]),
        .shamt(req_shamt[grant*SW +: SW]),
        .right(req_right[grant]),
        .arith(req_arith[grant]),
        .dout (sh_dout)
    );

    always_comb begin
        {found, grant} = rr_pick(req_valid, last_grant_q);
        can_accept = state_q == EMPTY || res_ready;
        req_ready = (found && can_accept && reset_n) ? NREQ'(1) << grant : '0;
        xfer = |(req_valid & req_ready);
        state_d = xfer ? FULL : (res_ready ? EMPTY : state_q);
        res_dout_d = xfer ? sh_dout : res_dout_q;
        res_id_d = xfer ? grant : res_id_q;
        last_grant_d = xfer ? grant : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            res_dout_q <= '0;
            res_id_q <= '0;
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            res_dout_q <= res_dout_d;
            res_id_q <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = state_q == FULL;
    assign res_dout = res_dout_q;
    assign res_id = res_id_q;
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational `shifter` datapath between NREQ independent requesters. Arbitration is round-robin, with a valid/ready handshake on each request port. The shifted result is captured in a single output register tagged with the requester ID. The block sits between the issuing units and the shared shifter, so each unit does not need its own barrel shifter.

Parameters:
WIDTH, 8, data width of operands and results
NREQ, 4, number of requesters (power of 2, >= 2)
SW (localparam), $clog2(WIDTH), shift-amount width
IDW (localparam), $clog2(NREQ), requester-ID width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  synchronous, active-low reset
req_valid  in  NREQ  request i is presenting an operation
req_ready  out  NREQ  request i is accepted this cycle (one-hot or zero)
req_din  in  NREQ*WIDTH  operand; slice i is [i*WIDTH +: WIDTH]
req_shamt  in  NREQ*SW  shift amount; slice i is [i*SW +: SW]
req_right  in  NREQ  1 = right shift, 0 = left shift
req_arith  in  NREQ  1 = arithmetic right shift; ignored when right = 0
res_valid  out  1  res_dout and res_id hold an unconsumed result
res_ready  in  1  consumer accepts the result this cycle
res_dout  out  WIDTH  shifted result
res_id  out  IDW  index of the requester that produced res_dout

Behaviour:
- Reset, while reset_n = 0 at a clk edge:
  - res_valid = 0, res_dout = 0, res_id = 0.
  - last_grant = NREQ-1, so requester 0 has highest priority first.
  - An in-flight result is discarded.
- Reset effect on req_ready: req_ready is forced to 0 during any cycle in which reset_n = 0.
- Output register states:
  - EMPTY (res_valid = 0).
  - FULL (res_valid = 1).
- Accept condition: can_accept = !res_valid || res_ready.
- Arbitration (combinational, each cycle):
  - Scan req_valid starting at (last_grant+1) mod NREQ, wrapping around.
  - The first asserted requester is the grant g.
  - req_ready[g] = can_accept; every other req_ready bit = 0.
  - If no req_valid bit is set, req_ready = 0.
- Transfer: a transfer occurs when req_valid[g] && req_ready[g]. On that edge:
  - res_dout <= shifter(req_din[g], req_shamt[g], req_right[g], req_arith[g]).
  - res_id <= g.
  - res_valid <= 1.
  - last_grant <= g.
- Drain: res_ready && res_valid with no transfer -> res_valid <= 0 (FULL -> EMPTY).
- Simultaneous drain and transfer: the new result replaces the old one and res_valid stays 1. This gives a throughput of 1 op per cycle.
- Backpressure: FULL && !res_ready -> req_ready = 0. res_dout and res_id stay stable, and last_grant is unchanged.
- Latency: the result is visible exactly 1 cycle after the transfer edge.
- Pointer updates: last_grant changes only on a transfer. Idle cycles and stalled cycles never advance the pointer.
- Requester protocol: a requester holds valid and its payload stable until it sees ready. Dropping valid before acceptance is legal, and that request is simply not served.
- Shift semantics (identical to `shifter`):
  - Left shift is logical.
  - Right shift is logical, or arithmetic when req_arith = 1.
  - shamt = 0 passes the operand through unchanged.
  - The maximum shift is WIDTH-1.
- Priority: there is no starvation. Every continuously asserted requester is served within NREQ transfers.

Decomposition:
- Package shift_arb_pkg:
  - typedef enum {EMPTY, FULL} outq_state_t.
  - localparam DEF_WIDTH = 8, DEF_NREQ = 4.
- Sub-modules:
  - One instance of the existing `shifter`, driven by the granted requester's mux output.
  - The round-robin priority scan stays inline as a function, not a separate module.

Test Plan:
1. Set res_valid = 1, then hold reset_n = 0 for 2 cycles -> res_valid = 0, res_dout = 0, res_id = 0, req_ready = 0. With all four requesters valid after reset, the first grant is req 0.
2. Shift modes on req 1: din = 8'hB4, shamt = 2, right = 1, arith = 1 -> next cycle res_dout = 8'hED, res_id = 1. Same operand with arith = 0 -> 8'h2D. Same operand with right = 0 -> 8'hD0.
3. Boundary shifts: din = 8'h01, shamt = 7, left -> 8'h80. din = 8'h80, shamt = 7, right, arith -> 8'hFF. din = 8'h5A, shamt = 0 -> 8'h5A.
4. Full throughput: all four req_valid held at 1 and res_ready = 1 -> one transfer per cycle, res_id sequence 0, 1, 2, 3, 0, 1.
5. Backpressure: result FULL and res_ready = 0 for 3 cycles -> req_ready = 0 throughout, res_dout and res_id unchanged. Raising res_ready for one cycle -> drain and new grant in the same cycle, with res_valid staying 1.
6. Skip fairness: last_grant = 2, only req 2 and req 0 valid -> next grant is 0, then 2. With no valid requests, last_grant is unchanged across idle cycles.
